stripes_neuron_serializer: RTL and testbench

- Transmit side of the Stripes bit-serial neuron path.
- Accepts a brick of Ti parallel N-bit neurons from the NBin/eDRAM read port over a valid/ready handshake.
- Emits each brick bit-serially, one bit per neuron per cycle, LSB first, for a per-brick precision of p cycles. Each cycle carries first/last framing and the precision that the SIP node slice consumes.
- Double-buffered (active shift register plus one shadow brick), so back-to-back bricks stream with no bubble.

---
 rtl/stripes_neuron_serializer.sv | 133 +++++++++++++
 tb/tb_stripes_neuron_serializer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/stripes_neuron_serializer.sv
// Stripes transmit-side serializer: takes a brick of Ti parallel N-bit neurons and
// streams it LSB first, one bit per lane per cycle, for the brick's effective precision.
module stripes_neuron_serializer #(
  parameter int N      = 16,
  parameter int Ti     = 16,
  parameter int PREC_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N*Ti-1:0]     i_brick,
  input  logic [PREC_W-1:0]   i_precision,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_stall,
  output logic [Ti-1:0]       o_bits,
  output logic                o_valid,
  output logic                o_first_cycle,
  output logic                o_last_cycle,
  output logic [PREC_W-1:0]   o_precision,
  output logic                o_busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [PREC_W-1:0] ONE  = PREC_W'(1);
  localparam logic [PREC_W-1:0] NMAX = PREC_W'(N);

  state_t              state_q, state_d;
  logic [N*Ti-1:0]     act_q, act_d, sh_q, sh_d;
  logic [PREC_W-1:0]   act_prec_q, act_prec_d, sh_prec_q, sh_prec_d;
  logic [PREC_W-1:0]   cnt_q, cnt_d;
  logic                sh_full_q, sh_full_d;
  logic                accept, consume, last_bit;

  // Zero or over-wide precision falls back to the full neuron width.
  function automatic logic [PREC_W-1:0] clamp_prec(input logic [PREC_W-1:0] p);
    if (p == '0 || p > NMAX) return NMAX;
    return p;
  endfunction

  function automatic logic [N*Ti-1:0] shift_lanes(input logic [N*Ti-1:0] v);
    logic [N*Ti-1:0] r;
    for (int k = 0; k < Ti; k++) r[k*N +: N] = v[k*N +: N] >> 1;
    return r;
  endfunction

  assign accept   = i_valid && !sh_full_q;
  assign consume  = (state_q == SHIFT) && !i_stall;
  assign last_bit = (cnt_q == act_prec_q - ONE);

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    act_prec_d = act_prec_q;
    sh_d       = sh_q;
    sh_prec_d  = sh_prec_q;
    sh_full_d  = sh_full_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          act_d      = i_brick;
          act_prec_d = clamp_prec(i_precision);
          cnt_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (consume && last_bit) begin
          // Refill from the shadow first, else straight from the input, so no bubble appears.
          if (sh_full_q) begin
            act_d      = sh_q;
            act_prec_d = sh_prec_q;
            sh_full_d  = 1'b0;
            cnt_d      = '0;
          end else if (accept) begin
            act_d      = i_brick;
            act_prec_d = clamp_prec(i_precision);
            cnt_d      = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (consume) begin
            cnt_d = cnt_q + ONE;
            act_d = shift_lanes(act_q);
          end
          if (accept) begin
            sh_d      = i_brick;
            sh_prec_d = clamp_prec(i_precision);
            sh_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      sh_full_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sh_full_q <= sh_full_d;
      cnt_q     <= cnt_d;
    end
  end

  // Brick payloads are only observed through the SHIFT-gated outputs, so they carry no reset.
  always_ff @(posedge clk) begin
    act_q      <= act_d;
    act_prec_q <= act_prec_d;
    sh_q       <= sh_d;
    sh_prec_q  <= sh_prec_d;
  end

  always_comb begin
    o_bits = '0;
    if (state_q == SHIFT) begin
      for (int k = 0; k < Ti; k++) o_bits[k] = act_q[k*N];
    end
  end

  assign o_valid       = (state_q == SHIFT);
  assign o_first_cycle = (state_q == SHIFT) && (cnt_q == '0);
  assign o_last_cycle  = (state_q == SHIFT) && last_bit;
  assign o_precision   = (state_q == SHIFT) ? act_prec_q : '0;
  assign o_ready       = !sh_full_q;
  assign o_busy        = (state_q == SHIFT) || sh_full_q;

endmodule

// File: tb/tb_stripes_neuron_serializer.sv
// Directed bench for stripes_neuron_serializer: single brick, back-to-back, clamp, stall, reset.
module tb_stripes_neuron_serializer;

  localparam int N = 16;
  localparam int Ti = 16;
  localparam int PREC_W = 5;

  logic              clk;
  logic              reset;
  logic [N*Ti-1:0]   i_brick;
  logic [PREC_W-1:0] i_precision;
  logic              i_valid;
  logic              o_ready;
  logic              i_stall;
  logic [Ti-1:0]     o_bits;
  logic              o_valid;
  logic              o_first_cycle;
  logic              o_last_cycle;
  logic [PREC_W-1:0] o_precision;
  logic              o_busy;

  int checks = 0;
  int failures = 0;

  stripes_neuron_serializer #(.N(N), .Ti(Ti), .PREC_W(PREC_W)) dut (
    .clk(clk), .reset(reset), .i_brick(i_brick), .i_precision(i_precision),
    .i_valid(i_valid), .o_ready(o_ready), .i_stall(i_stall), .o_bits(o_bits),
    .o_valid(o_valid), .o_first_cycle(o_first_cycle), .o_last_cycle(o_last_cycle),
    .o_precision(o_precision), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*Ti-1:0] brick_idx();
    logic [N*Ti-1:0] b;
    for (int k = 0; k < Ti; k++) b[k*N +: N] = N'(k);
    return b;
  endfunction

  function automatic logic [N*Ti-1:0] brick_all(input logic [N-1:0] v);
    logic [N*Ti-1:0] b;
    for (int k = 0; k < Ti; k++) b[k*N +: N] = v;
    return b;
  endfunction

  // Lane k of brick_idx carries value k, so lane k emits bit b of k.
  function automatic logic [Ti-1:0] idx_bits(input int b);
    logic [Ti-1:0] r;
    for (int k = 0; k < Ti; k++) r[k] = 1'((k >> b) & 1);
    return r;
  endfunction

  logic [Ti-1:0] exp_bits;
  logic          acc;
  int            idx;
  int            cnt;
  int            plist[3];
  int            elen[3];
  logic          ready_tab[9];
  logic [N-1:0]  pat[3];

  initial begin
    reset = 1'b0; i_brick = '0; i_precision = '0; i_valid = 1'b0; i_stall = 1'b0;
    step(); step();
    chk("rst_valid", o_valid, 0);
    chk("rst_first", o_first_cycle, 0);
    chk("rst_last", o_last_cycle, 0);
    chk("rst_bits", o_bits, 0);
    chk("rst_prec", o_precision, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_ready, 1);
    reset = 1'b1;
    step();

    // Single brick, p=4
    i_brick = brick_idx(); i_precision = 5'd4; i_valid = 1'b1;
    chk("t1_idle_valid", o_valid, 0);
    step();
    i_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t1_valid_c%0d", c), o_valid, 1);
      chk($sformatf("t1_bits_c%0d", c), o_bits, idx_bits(c));
      chk($sformatf("t1_first_c%0d", c), o_first_cycle, (c == 0));
      chk($sformatf("t1_last_c%0d", c), o_last_cycle, (c == 3));
      chk($sformatf("t1_prec_c%0d", c), o_precision, 4);
      step();
    end
    chk("t1_done_valid", o_valid, 0);
    chk("t1_done_busy", o_busy, 0);
    step();

    // Back-to-back bricks, p=3, valid held
    pat[0] = 16'hFFFF; pat[1] = 16'h0000; pat[2] = 16'hAAAA;
    ready_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    idx = 0;
    i_brick = brick_all(pat[0]); i_precision = 5'd3; i_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      acc = i_valid && o_ready;
      step();
      if (acc) begin
        idx++;
        if (idx < 3) i_brick = brick_all(pat[idx]);
        else i_valid = 1'b0;
      end
      exp_bits = {Ti{pat[c / 3][c % 3]}};
      chk($sformatf("t2_valid_c%0d", c), o_valid, 1);
      chk($sformatf("t2_first_c%0d", c), o_first_cycle, (c % 3 == 0));
      chk($sformatf("t2_last_c%0d", c), o_last_cycle, (c % 3 == 2));
      chk($sformatf("t2_bits_c%0d", c), o_bits, exp_bits);
      chk($sformatf("t2_ready_c%0d", c), o_ready, ready_tab[c]);
    end
    step();
    chk("t2_done_valid", o_valid, 0);

    // Precision clamp
    plist = '{0, 20, 1};
    elen  = '{16, 16, 1};
    for (int t = 0; t < 3; t++) begin
      i_brick = brick_all(16'h8001); i_precision = PREC_W'(plist[t]); i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      chk($sformatf("t3_prec_p%0d", plist[t]), o_precision, elen[t]);
      cnt = 0;
      while (o_valid && cnt < 40) begin
        exp_bits = (cnt == 0 || cnt == 15) ? {Ti{1'b1}} : '0;
        chk($sformatf("t3_bits_p%0d_c%0d", plist[t], cnt), o_bits, exp_bits);
        chk($sformatf("t3_first_p%0d_c%0d", plist[t], cnt), o_first_cycle, (cnt == 0));
        chk($sformatf("t3_last_p%0d_c%0d", plist[t], cnt), o_last_cycle, (cnt == elen[t] - 1));
        cnt++;
        step();
      end
      chk($sformatf("t3_len_p%0d", plist[t]), cnt, elen[t]);
    end

    // Stall for 3 cycles at cnt==2, shadow accepted during stall
    i_brick = brick_idx(); i_precision = 5'd4; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    chk("t4_bits_c0", o_bits, idx_bits(0));
    chk("t4_first_c0", o_first_cycle, 1);
    step();
    chk("t4_bits_c1", o_bits, idx_bits(1));
    step();
    chk("t4_bits_c2", o_bits, idx_bits(2));
    i_stall = 1'b1; i_brick = brick_all(16'h0001); i_precision = 5'd2; i_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      i_valid = 1'b0;
      chk($sformatf("t4_stall_valid_s%0d", s), o_valid, 1);
      chk($sformatf("t4_stall_bits_s%0d", s), o_bits, idx_bits(2));
      chk($sformatf("t4_stall_first_s%0d", s), o_first_cycle, 0);
      chk($sformatf("t4_stall_last_s%0d", s), o_last_cycle, 0);
      chk($sformatf("t4_stall_ready_s%0d", s), o_ready, 0);
    end
    i_stall = 1'b0;
    step();
    chk("t4_bits_c3", o_bits, idx_bits(3));
    chk("t4_last_c3", o_last_cycle, 1);
    step();
    chk("t4_shadow_first", o_first_cycle, 1);
    chk("t4_shadow_prec", o_precision, 2);
    chk("t4_shadow_bits0", o_bits, 16'hFFFF);
    step();
    chk("t4_shadow_last", o_last_cycle, 1);
    chk("t4_shadow_bits1", o_bits, 16'h0000);
    step();
    chk("t4_done_valid", o_valid, 0);

    // Reset mid-brick with shadow full
    i_brick = brick_idx(); i_precision = 5'd4; i_valid = 1'b1;
    step();
    i_brick = brick_all(16'hFFFF);
    step();
    i_valid = 1'b0;
    chk("t5_pre_busy", o_busy, 1);
    chk("t5_pre_ready", o_ready, 0);
    chk("t5_pre_bits_c1", o_bits, idx_bits(1));
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("t5_rst_valid", o_valid, 0);
    chk("t5_rst_ready", o_ready, 1);
    chk("t5_rst_busy", o_busy, 0);
    chk("t5_rst_bits", o_bits, 0);
    i_brick = brick_all(16'h0002); i_precision = 5'd2; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    chk("t5_new_first", o_first_cycle, 1);
    chk("t5_new_bits0", o_bits, 16'h0000);
    chk("t5_new_prec", o_precision, 2);
    step();
    chk("t5_new_last", o_last_cycle, 1);
    chk("t5_new_bits1", o_bits, 16'hFFFF);
    step();
    chk("t5_new_done", o_valid, 0);
    chk("t5_new_busy", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
